burst_mem_resp: RTL
===================

BURST_MEM_RESP -- requirements
Module: burst_mem_resp

Interface
REQ-001 SHALL have parameter addr_width, default 32, meaning the byte address width.
REQ-002 SHALL have parameter data_width, default 32, meaning the beat width in bits, a power of 2 and at least 8.
REQ-003 SHALL have parameter mem_depth, default 1024, meaning the number of data_width words of storage, a power of 2.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-006 SHALL have write request ports: wr_req in 1; wr_gnt out 1; wr_len in 16 (bytes); wr_addr in addr_width (byte address).
REQ-007 SHALL have write data ports: wr_data in data_width; wr_valid in 1; wr_last in 1; wr_ready out 1; wr_done out 1.
REQ-008 SHALL have read request ports: rd_req in 1; rd_gnt out 1; rd_len in 16; rd_addr in addr_width.
REQ-009 SHALL have read data ports: rd_data out data_width; rd_valid out 1; rd_ready in 1; rd_done out 1.
REQ-010 SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, WR_BURST, WR_RESP and RD_BURST, and SHALL serve one transaction at a time.
REQ-012 SHALL drive wr_gnt = IDLE && wr_req and rd_gnt = IDLE && rd_req && !wr_req, both combinational: write has fixed priority on a simultaneous request.
REQ-013 SHALL capture the address and length into local registers on a grant and move to WR_BURST or RD_BURST in the next cycle.
REQ-014 SHALL compute beats = len >> log2(data_width/8), with beats = 1 when that result is 0; low length bits are ignored.
REQ-015 SHALL compute the word index of beat k as ((addr >> log2(data_width/8)) + k) mod mem_depth, so bursts wrap around the memory.
REQ-016 SHALL drive wr_ready high only in WR_BURST; each wr_valid && wr_ready writes wr_data to the current index and increments the beat counter.
REQ-017 SHALL move from WR_BURST to WR_RESP on the handshake of beat beats-1, and WR_RESP SHALL pulse wr_done for exactly 1 cycle and then return to IDLE.
REQ-018 SHALL, in RD_BURST, read word 0 on entry and present it with rd_valid in the following cycle.
REQ-019 SHALL hold rd_data and rd_valid stable until rd_ready is seen; after each handshake the next beat SHALL be valid in the next cycle, giving no bubble.
REQ-020 SHALL assert rd_done together with rd_valid on the final beat only; the final handshake returns the block to IDLE.
REQ-021 SHALL give wr_req and rd_req no effect outside IDLE, and SHALL hold every gnt low there.
REQ-022 SHALL make a write followed by a read of the same address return the written data, with no hazard.

Reset
REQ-023 SHALL, when rst is high, force IDLE, clear the counters and set wr_gnt, wr_ready, wr_done, rd_gnt, rd_valid, rd_done and busy to 0 and rd_data to 0 on the next edge.
REQ-024 SHALL, on reset mid-burst, abandon the burst with no wr_done or rd_done; words already written stay written and memory contents are not cleared.

Configuration
REQ-025 SHALL support macro BURST_MEM_RESP_ERR_CHK_EN: when it is defined, add an output err (1 bit) that is sticky until rst.
REQ-026 SHALL, with the macro defined, set err on a wr_last handshake before the final beat; the burst SHALL then terminate as if that beat were the final beat.
REQ-027 SHALL, with the macro defined, also set err on a final write beat whose wr_last is low.
REQ-028 SHALL, without the macro, have no err port, ignore wr_last and decide burst length by beats only.

Structure
REQ-029 SHALL place the state enum, and a constant BYTES_PER_BEAT derived from data_width, in the shared package burst_mem_pkg.
REQ-030 SHALL instance the storage as sub-module burst_mem_array: single-port, synchronous read with one-cycle latency, synchronous write, no reset.

Verification
REQ-031 SHALL cover: write wr_addr=0x40, wr_len=128 with data_width=32 -> 32 beats written, wr_done pulses 1 cycle after beat 31, busy then falls.
REQ-032 SHALL cover: read rd_addr=0x40, rd_len=128 with rd_ready held high -> 32 back-to-back beats, first beat 2 cycles after rd_gnt, data matching, rd_done on beat 31 only.
REQ-033 SHALL cover: wr_req and rd_req in the same cycle -> wr_gnt=1, rd_gnt=0; the read is granted in the first IDLE cycle after wr_done.
REQ-034 SHALL cover: read with rd_ready toggled randomly -> rd_data stable while stalled, with no beat lost or repeated.
REQ-035 SHALL cover: write at index mem_depth-2 with 4 beats -> beats land at mem_depth-2, mem_depth-1, 0 and 1.
REQ-036 SHALL cover: rst pulsed during beat 10 of a write, and (macro defined) wr_last on beat 5 of 32 -> outputs at reset values; err=1 and wr_done follows beat 5.

Source files
------------

// File: rtl/burst_mem_pkg.sv
// Shared definitions for the burst memory responder.
//   state_e        : responder FSM states
//   BYTES_PER_BEAT : bytes per beat for the default 32-bit data width
//   beat_shift()   : log2(bytes per beat) for any data width; byte address/length -> beats
package burst_mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWrBurst,
    StWrResp,
    StRdBurst
  } state_e;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned BYTES_PER_BEAT     = DEFAULT_DATA_WIDTH / 8;

  function automatic int unsigned beat_shift(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/burst_mem_array.sv
// Single-port storage for burst_mem_resp.
//   clk_i   : clock
//   we_i    : write wdata_i to word idx_i
//   re_i    : read word idx_i; rdata_o updates one cycle later and holds otherwise
//   idx_i   : word index
//   wdata_i : write data
//   rdata_o : registered read data
// No reset: contents survive a responder reset.
module burst_mem_array #(
  parameter int unsigned data_width = 32,
  parameter int unsigned mem_depth  = 1024
) (
  input  logic                         clk_i,
  input  logic                         we_i,
  input  logic                         re_i,
  input  logic [$clog2(mem_depth)-1:0] idx_i,
  input  logic [data_width-1:0]        wdata_i,
  output logic [data_width-1:0]        rdata_o
);

  logic [data_width-1:0] mem_q [mem_depth];
  logic [data_width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/burst_mem_resp.sv
// Burst memory responder: serves one write or read burst at a time from local storage.
//   clk, rst                                  : clock, synchronous active-high reset
//   wr_req/wr_gnt/wr_len/wr_addr              : write request (byte length, byte address)
//   wr_data/wr_valid/wr_last/wr_ready/wr_done : write beats; wr_done pulses after the burst
//   rd_req/rd_gnt/rd_len/rd_addr              : read request (write wins on a tie)
//   rd_data/rd_valid/rd_ready/rd_done         : read beats; rd_done marks the final beat
//   busy                                      : not idle
// Optional: define BURST_MEM_RESP_ERR_CHK_EN to add a sticky err output flagging wr_last
// disagreeing with the computed burst length (an early wr_last also ends the burst).
module burst_mem_resp
  import burst_mem_pkg::*;
#(
  parameter int unsigned addr_width = 32,
  parameter int unsigned data_width = 32,
  parameter int unsigned mem_depth  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  output logic                  wr_gnt,
  input  logic [15:0]           wr_len,
  input  logic [addr_width-1:0] wr_addr,
  input  logic [data_width-1:0] wr_data,
  input  logic                  wr_valid,
  input  logic                  wr_last,
  output logic                  wr_ready,
  output logic                  wr_done,
  input  logic                  rd_req,
  output logic                  rd_gnt,
  input  logic [15:0]           rd_len,
  input  logic [addr_width-1:0] rd_addr,
  output logic [data_width-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_done,
`ifdef BURST_MEM_RESP_ERR_CHK_EN
  output logic                  err,
`endif
  output logic                  busy
);

  localparam int unsigned BeatShift = beat_shift(data_width);
  localparam int unsigned IdxW      = $clog2(mem_depth);

  state_e          state_q, state_d;
  logic [IdxW-1:0] base_q, base_d;     // word index of beat 0
  logic [15:0]     last_q, last_d;     // index of the final beat (beats - 1)
  logic [15:0]     cnt_q, cnt_d;       // current beat
  logic            rd_valid_q, rd_valid_d;
  logic [15:0]     req_beats;
  logic            final_beat;
  logic            wr_end;
  logic            mem_we, mem_re;
  logic [IdxW-1:0] mem_idx;
  logic [data_width-1:0] mem_rdata;

  assign wr_gnt     = (state_q == StIdle) && wr_req && !rst;
  assign rd_gnt     = (state_q == StIdle) && rd_req && !wr_req && !rst;
  assign final_beat = (cnt_q == last_q);
  assign req_beats  = (wr_gnt ? wr_len : rd_len) >> BeatShift;

`ifdef BURST_MEM_RESP_ERR_CHK_EN
  logic err_q, err_d;
  assign wr_end = final_beat || wr_last;
  assign err_d  = err_q || ((state_q == StWrBurst) && wr_valid && (wr_last != final_beat));
  assign err    = err_q;
`else
  logic unused_wr_last;
  assign unused_wr_last = wr_last;
  assign wr_end         = final_beat;
`endif

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    rd_valid_d = rd_valid_q;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_idx    = base_q + IdxW'(cnt_q);
    unique case (state_q)
      StIdle: begin
        if (wr_gnt || rd_gnt) begin
          base_d     = IdxW'((wr_gnt ? wr_addr : rd_addr) >> BeatShift);
          last_d     = (req_beats == 16'd0) ? 16'd0 : req_beats - 16'd1;
          cnt_d      = 16'd0;
          rd_valid_d = 1'b0;
          state_d    = wr_gnt ? StWrBurst : StRdBurst;
        end
      end
      StWrBurst: begin
        if (wr_valid) begin
          mem_we = !rst;
          cnt_d  = cnt_q + 16'd1;
          if (wr_end) state_d = StWrResp;
        end
      end
      StWrResp: state_d = StIdle;
      StRdBurst: begin
        if (!rd_valid_q) begin
          // Entry: fetch beat 0, visible next cycle.
          mem_re     = 1'b1;
          rd_valid_d = 1'b1;
        end else if (rd_ready) begin
          if (final_beat) begin
            rd_valid_d = 1'b0;
            state_d    = StIdle;
          end else begin
            // Prefetch the next beat in the handshake cycle so there is no bubble.
            mem_re  = 1'b1;
            mem_idx = base_q + IdxW'(cnt_q + 16'd1);
            cnt_d   = cnt_q + 16'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      base_q     <= '0;
      last_q     <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
`ifdef BURST_MEM_RESP_ERR_CHK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
`ifdef BURST_MEM_RESP_ERR_CHK_EN
      err_q      <= err_d;
`endif
    end
  end

  burst_mem_array #(
    .data_width(data_width),
    .mem_depth (mem_depth)
  ) u_mem (
    .clk_i  (clk),
    .we_i   (mem_we),
    .re_i   (mem_re),
    .idx_i  (mem_idx),
    .wdata_i(wr_data),
    .rdata_o(mem_rdata)
  );

  assign wr_ready = (state_q == StWrBurst);
  assign wr_done  = (state_q == StWrResp);
  assign rd_valid = rd_valid_q;
  assign rd_done  = rd_valid_q && final_beat;
  // Gated so rd_data reads 0 out of reset even though the array itself is not reset.
  assign rd_data  = rd_valid_q ? mem_rdata : '0;
  assign busy     = (state_q != StIdle);

endmodule
